// File: rtl/adc_capture_multich.sv
// Multi-channel multiplexed ADC capture front end: conversion clock and channel
// select generation, sample de-interleave, offset-binary/two's-complement
// conversion, per-channel boxcar averaging with decimation, and a frame FIFO
// feeding an AXI-Stream-style master port.
module adc_capture_multich #(
  parameter int unsigned ADC_W        = 10,
  parameter int unsigned CH_COUNT     = 2,
  parameter int unsigned SEL_W        = 1,
  parameter int unsigned OUT_W        = 16,
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned MAX_AVG_LOG2 = 4,
  parameter int unsigned FIFO_DEPTH   = 8,
  localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [2:0]                avg_log2,
  input  logic                      twos_comp,
  input  logic                      overflow_clr,
  input  logic [ADC_W-1:0]          adc_input,
  output logic [SEL_W-1:0]          adc_sel,
  output logic                      adc_clk,
  output logic [CH_COUNT*OUT_W-1:0] tdata_m,
  output logic                      tvalid_m,
  input  logic                      tready_m,
  output logic                      overflow,
  output logic [LVL_W-1:0]          fifo_level
);

  localparam int unsigned ACC_W   = ADC_W + MAX_AVG_LOG2;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned AVG_W   = $clog2(MAX_AVG_LOG2 + 1);
  localparam int unsigned WIN_W   = (MAX_AVG_LOG2 > 0) ? MAX_AVG_LOG2 : 1;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FRM_W   = CH_COUNT * OUT_W;
  localparam int unsigned LAST_CH = CH_COUNT - 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             adc_clk_q, adc_clk_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] cap_ch_q, cap_ch_d;
  logic             cap_vld_q, cap_vld_d;
  logic [ADC_W-1:0] smp_q, smp_d;
  logic [AVG_W-1:0] avg_q, avg_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [ACC_W-1:0] acc_q [CH_COUNT];
  logic [ACC_W-1:0] acc_d [CH_COUNT];
  logic [FRM_W-1:0] res_q, res_d;
  logic             res_vld_q, res_vld_d;
  logic [FRM_W-1:0] mem_q [FIFO_DEPTH];
  logic [FRM_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             tvalid_q, tvalid_d;
  logic [FRM_W-1:0] tdata_q, tdata_d;
  logic             ovf_q, ovf_d;

  logic [ADC_W-1:0] smp_conv;
  logic [ACC_W-1:0] smp_ext;
  logic [AVG_W-1:0] avg_in;
  logic             full, pop, push_ok, drop;

  // Window sum -> average: arithmetic shift for signed data, then extend to OUT_W
  function automatic logic [OUT_W-1:0] scale(input logic [ACC_W-1:0] v,
                                             input logic             tc,
                                             input logic [AVG_W-1:0] sh);
    logic signed [ACC_W:0] sx;
    sx = $signed({tc & v[ACC_W-1], v});
    return OUT_W'(sx >>> sh);
  endfunction

  // Divider, capture, de-interleave and per-channel window accumulation
  always_comb begin
    div_d     = div_q;
    adc_clk_d = adc_clk_q;
    ch_d      = ch_q;
    cap_ch_d  = cap_ch_q;
    cap_vld_d = 1'b0;
    smp_d     = smp_q;
    avg_d     = avg_q;
    win_d     = win_q;
    acc_d     = acc_q;
    res_d     = res_q;
    res_vld_d = 1'b0;

    smp_conv = {~smp_q[ADC_W-1], smp_q[ADC_W-2:0]};
    smp_ext  = twos_comp ? ACC_W'($signed(smp_conv)) : ACC_W'(smp_q);
    avg_in   = (32'(avg_log2) > MAX_AVG_LOG2) ? AVG_W'(MAX_AVG_LOG2) : AVG_W'(avg_log2);

    if (!enable) begin
      adc_clk_d = 1'b0;
      ch_d      = '0;
      win_d     = '0;
      for (int k = 0; k < CH_COUNT; k++) acc_d[k] = '0;
    end else begin
      if (div_q == DIV_W'(CLK_DIV - 1)) begin
        div_d     = '0;
        adc_clk_d = ~adc_clk_q;
        if (!adc_clk_q) begin
          cap_vld_d = 1'b1;
          smp_d     = adc_input;
          cap_ch_d  = ch_q;
          ch_d      = (ch_q == SEL_W'(LAST_CH)) ? '0 : ch_q + 1'b1;
        end
      end else begin
        div_d = div_q + 1'b1;
      end

      if (cap_vld_q) begin
        // window exponent is sampled only on the first sample of a window
        if (cap_ch_q == '0 && win_q == '0) avg_d = avg_in;
        for (int k = 0; k < CH_COUNT; k++) begin
          if (SEL_W'(k) == cap_ch_q) acc_d[k] = acc_q[k] + smp_ext;
        end
        if (cap_ch_q == SEL_W'(LAST_CH)) begin
          if (&(win_q | ({WIN_W{1'b1}} << avg_q))) begin
            for (int k = 0; k < CH_COUNT; k++) begin
              res_d[k*OUT_W +: OUT_W] = scale(acc_d[k], twos_comp, avg_q);
              acc_d[k]                = '0;
            end
            res_vld_d = 1'b1;
            win_d     = '0;
          end else begin
            win_d = win_q + 1'b1;
          end
        end
      end
    end
  end

  // First-word-fall-through frame FIFO with sticky drop flag
  always_comb begin
    full    = (lvl_q == LVL_W'(FIFO_DEPTH));
    pop     = tvalid_q & tready_m;
    push_ok = res_vld_q & (~full | pop);
    drop    = res_vld_q & full & ~pop;
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    if (push_ok) begin
      mem_d[wp_q] = res_q;
      wp_d        = wp_q + 1'b1;
    end
    if (pop) rp_d = rp_q + 1'b1;
    lvl_d    = lvl_q + LVL_W'(push_ok) - LVL_W'(pop);
    tvalid_d = (lvl_d != '0);
    tdata_d  = mem_d[rp_d];
    ovf_d    = drop | (ovf_q & ~overflow_clr);
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q     <= '0;
      adc_clk_q <= 1'b0;
      ch_q      <= '0;
      cap_ch_q  <= '0;
      cap_vld_q <= 1'b0;
      smp_q     <= '0;
      avg_q     <= '0;
      win_q     <= '0;
      for (int k = 0; k < CH_COUNT; k++) acc_q[k] <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      lvl_q     <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      adc_clk_q <= adc_clk_d;
      ch_q      <= ch_d;
      cap_ch_q  <= cap_ch_d;
      cap_vld_q <= cap_vld_d;
      smp_q     <= smp_d;
      avg_q     <= avg_d;
      win_q     <= win_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      mem_q     <= mem_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      lvl_q     <= lvl_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      ovf_q     <= ovf_d;
    end
  end

  assign adc_clk    = adc_clk_q;
  assign adc_sel    = ch_q;
  assign tdata_m    = tdata_q;
  assign tvalid_m   = tvalid_q;
  assign overflow   = ovf_q;
  assign fifo_level = lvl_q;

endmodule

// File: tb/tb_adc_capture_multich.sv
// Directed bench for adc_capture_multich with default parameters.
module tb_adc_capture_multich;

  localparam int unsigned ADC_W = 10;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned LVL_W = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [2:0]        avg_log2;
  logic              twos_comp;
  logic              overflow_clr;
  logic [ADC_W-1:0]  adc_input;
  logic [0:0]        adc_sel;
  logic              adc_clk;
  logic [2*OUT_W-1:0] tdata_m;
  logic              tvalid_m;
  logic              tready_m;
  logic              overflow;
  logic [LVL_W-1:0]  fifo_level;

  logic [ADC_W-1:0]  ch_val [2];
  logic              seq_en = 1'b0;
  logic              rise = 1'b0;
  logic              prev_adc_clk = 1'b0;
  int                cap_cnt = 0;
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  assign adc_input = ch_val[adc_sel];

  adc_capture_multich dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .avg_log2    (avg_log2),
    .twos_comp   (twos_comp),
    .overflow_clr(overflow_clr),
    .adc_input   (adc_input),
    .adc_sel     (adc_sel),
    .adc_clk     (adc_clk),
    .tdata_m     (tdata_m),
    .tvalid_m    (tvalid_m),
    .tready_m    (tready_m),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock step, sampled at the falling edge; models the ADC channel sequence
  task automatic tick();
    @(negedge clk);
    rise = (adc_clk === 1'b1) && (prev_adc_clk === 1'b0);
    prev_adc_clk = adc_clk;
    if (rise) begin
      cap_cnt++;
      if (seq_en && adc_sel == 1'b1) ch_val[0] = ch_val[0] + 1'b1;
    end
  endtask

  task automatic wait_rise(input int maxc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rise && n < maxc);
    chk("rise_timeout", 64'(rise), 64'd1);
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    while (tvalid_m !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    chk("tvalid_timeout", 64'(tvalid_m), 64'd1);
  endtask

  task automatic restart();
    enable   = 1'b0;
    tready_m = 1'b1;
    repeat (12) tick();
  endtask

  initial begin
    int n;
    int n8;
    logic seen8;
    logic ov_at8;

    reset_n = 1'b0; enable = 1'b0; avg_log2 = 3'd0; twos_comp = 1'b0;
    overflow_clr = 1'b0; tready_m = 1'b0;
    ch_val[0] = '0; ch_val[1] = '0;
    repeat (3) tick();
    chk("rst_adc_clk", 64'(adc_clk), 64'd0);
    chk("rst_adc_sel", 64'(adc_sel), 64'd0);
    chk("rst_tvalid", 64'(tvalid_m), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_tdata", 64'(tdata_m), 64'd0);

    // Clocking, channel sequencing and single-frame latency
    ch_val[0] = 10'h123; ch_val[1] = 10'h0AB;
    reset_n = 1'b1; enable = 1'b1; tready_m = 1'b1;
    wait_rise(20, n);
    chk("t1_first_rise", 64'(n), 64'd2);
    chk("t1_sel_after_ch0", 64'(adc_sel), 64'd1);
    wait_rise(20, n);
    chk("t1_adc_clk_period", 64'(n), 64'd4);
    chk("t1_sel_after_ch1", 64'(adc_sel), 64'd0);
    tick();
    chk("t1_adc_clk_high", 64'(adc_clk), 64'd1);
    chk("t1_tvalid_early", 64'(tvalid_m), 64'd0);
    tick();
    chk("t1_adc_clk_low", 64'(adc_clk), 64'd0);
    chk("t1_tvalid_latency", 64'(tvalid_m), 64'd1);
    chk("t1_tdata", 64'(tdata_m), 64'h00AB_0123);
    tick();
    wait_valid(40, n);
    chk("t1_frame_interval", 64'(n + 1), 64'd8);

    // Sample conversion
    restart();
    twos_comp = 1'b1; ch_val[0] = 10'h3FF; ch_val[1] = 10'h000;
    enable = 1'b1;
    wait_valid(60, n);
    chk("t2_twos", 64'(tdata_m), 64'hFE00_01FF);
    restart();
    twos_comp = 1'b0;
    enable = 1'b1;
    wait_valid(60, n);
    chk("t2_unsigned", 64'(tdata_m), 64'h0000_03FF);

    // Averaging over 4 frames
    restart();
    avg_log2 = 3'd2; seq_en = 1'b1; ch_val[0] = 10'd100; ch_val[1] = 10'd7;
    cap_cnt = 0; enable = 1'b1;
    n = 0; n8 = -100;
    while (tvalid_m !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (cap_cnt == 8 && n8 < 0) n8 = n;
    end
    chk("t3_avg_frame", 64'(tdata_m), 64'h0007_0065);
    chk("t3_capture_count", 64'(cap_cnt), 64'd8);
    chk("t3_latency", 64'(n - n8), 64'd2);
    tick();
    wait_valid(80, n);
    chk("t3_window_interval", 64'(n + 1), 64'd32);
    chk("t3_second_frame", 64'(tdata_m), 64'h0007_0069);

    // Exponent above the maximum is clamped to 16 frames
    restart();
    avg_log2 = 3'd7; ch_val[0] = 10'd200; ch_val[1] = 10'd7;
    cap_cnt = 0; enable = 1'b1;
    wait_valid(400, n);
    chk("t3_clamp_frame", 64'(tdata_m), 64'h0007_00CF);
    chk("t3_clamp_captures", 64'(cap_cnt), 64'd32);

    // Signed average rounds toward minus infinity
    restart();
    avg_log2 = 3'd1; twos_comp = 1'b1; ch_val[0] = 10'h1FF; ch_val[1] = 10'h000;
    enable = 1'b1;
    wait_valid(80, n);
    chk("t3_floor_frame", 64'(tdata_m), 64'hFE00_FFFF);

    // Fill, overflow, in-order drain, clear
    restart();
    avg_log2 = 3'd0; twos_comp = 1'b0; ch_val[0] = 10'h010; ch_val[1] = 10'h055;
    tready_m = 1'b0; enable = 1'b1;
    n = 0; seen8 = 1'b0; ov_at8 = 1'b1;
    while (overflow !== 1'b1 && n < 300) begin
      tick();
      n++;
      if (fifo_level == 4'd8 && !seen8) begin
        seen8 = 1'b1;
        ov_at8 = overflow;
      end
    end
    chk("t4_overflow_set", 64'(overflow), 64'd1);
    chk("t4_no_overflow_at_fill", 64'(ov_at8), 64'd0);
    chk("t4_level_full", 64'(fifo_level), 64'd8);
    enable = 1'b0;
    repeat (4) tick();
    tready_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain_valid", 64'(tvalid_m), 64'd1);
      chk("t4_drain_data", 64'(tdata_m), {32'd0, 16'h0055, 16'(16'h0010 + i)});
      tick();
    end
    chk("t4_empty_valid", 64'(tvalid_m), 64'd0);
    chk("t4_empty_level", 64'(fifo_level), 64'd0);
    chk("t4_overflow_sticky", 64'(overflow), 64'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("t4_overflow_cleared", 64'(overflow), 64'd0);

    // Push into a full FIFO in the same cycle as a pop
    tready_m = 1'b0; ch_val[0] = 10'h030; enable = 1'b1;
    n = 0;
    while (fifo_level !== 4'd8 && n < 300) begin
      tick();
      n++;
    end
    chk("t5_level_full", 64'(fifo_level), 64'd8);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(rise && adc_sel == 1'b0) && n < 50);
    tick();
    tready_m = 1'b1;
    tick();
    tready_m = 1'b0;
    chk("t5_level_kept", 64'(fifo_level), 64'd8);
    chk("t5_no_overflow", 64'(overflow), 64'd0);
    chk("t5_tvalid", 64'(tvalid_m), 64'd1);
    chk("t5_head_frame", 64'(tdata_m), 64'h0055_0031);

    // Enable drop mid-window discards the partial window
    restart();
    seq_en = 1'b0; avg_log2 = 3'd1; ch_val[0] = 10'h100; ch_val[1] = 10'h200;
    cap_cnt = 0; enable = 1'b1;
    n = 0;
    while (cap_cnt < 2 && n < 50) begin
      tick();
      n++;
    end
    repeat (3) tick();
    enable = 1'b0;
    repeat (2) tick();
    chk("t6_adc_clk_disabled", 64'(adc_clk), 64'd0);
    chk("t6_sel_disabled", 64'(adc_sel), 64'd0);
    repeat (5) tick();
    chk("t6_adc_clk_still_low", 64'(adc_clk), 64'd0);
    chk("t6_no_partial_frame", 64'(tvalid_m), 64'd0);
    ch_val[0] = 10'h010; ch_val[1] = 10'h020;
    cap_cnt = 0; enable = 1'b1;
    n = 0;
    while (cap_cnt < 1 && n < 50) begin
      tick();
      n++;
    end
    chk("t6_first_capture_ch0", 64'(adc_sel), 64'd1);
    wait_valid(80, n);
    chk("t6_fresh_window", 64'(tdata_m), 64'h0020_0010);

    // Asynchronous reset while running
    tready_m = 1'b0;
    n = 0;
    while (!(fifo_level >= 4'd1 && adc_clk === 1'b1 && adc_sel == 1'b1) && n < 100) begin
      tick();
      n++;
    end
    chk("t6_pre_reset_busy", 64'(tvalid_m), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_arst_adc_clk", 64'(adc_clk), 64'd0);
    chk("t6_arst_adc_sel", 64'(adc_sel), 64'd0);
    chk("t6_arst_tvalid", 64'(tvalid_m), 64'd0);
    chk("t6_arst_overflow", 64'(overflow), 64'd0);
    chk("t6_arst_level", 64'(fifo_level), 64'd0);
    chk("t6_arst_tdata", 64'(tdata_m), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    enable = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_capture_multich.md
Name: adc_capture_multich

Overview:
Parametrised successor to the dual-channel AD9201 capture front end. It drives a time-multiplexed multi-channel ADC: it generates the conversion clock and the channel-select lines, and de-interleaves the returned samples. Each sample is converted to offset-binary or two's-complement form. Optional per-channel boxcar averaging with decimation is applied. Whole frames (one result per channel) pass through an elastic FIFO to an AXI-Stream-style master port feeding dsp_subsystem.

Parameters:
ADC_W, 10, ADC sample width in bits.
CH_COUNT, 2, number of multiplexed channels (≥2).
SEL_W, 1, width of adc_sel; equals clog2(CH_COUNT).
OUT_W, 16, per-channel output field width; must be ≥ ADC_W.
CLK_DIV, 2, adc_clk half-period in clk cycles (≥1).
MAX_AVG_LOG2, 4, largest averaging exponent supported.
FIFO_DEPTH, 8, frame FIFO depth; power of two.

Ports:
clk  in  1  system clock (hclk domain)
reset_n  in  1  asynchronous active-low reset
enable  in  1  capture enable
avg_log2  in  3  averaging exponent; window = 2^avg_log2 frames
twos_comp  in  1  1: invert sample MSB and sign-extend; 0: zero-extend
overflow_clr  in  1  clears the sticky overflow flag
adc_input  in  ADC_W  ADC data bus
adc_sel  out  SEL_W  channel select to the ADC mux
adc_clk  out  1  ADC conversion clock
tdata_m  out  CH_COUNT*OUT_W  frame data; channel k occupies bits [k*OUT_W +: OUT_W]
tvalid_m  out  1  frame valid
tready_m  in  1  downstream ready
overflow  out  1  sticky: a frame was dropped
fifo_level  out  clog2(FIFO_DEPTH+1)  number of frames held in the FIFO

Behaviour:
- Reset: the following are all 0 — adc_clk, adc_sel, tvalid_m, overflow, fifo_level, tdata_m, divider, channel index, accumulators, window counter.

Clocking and capture:
- Divider counts 0..CLK_DIV-1; adc_clk toggles on wrap. Period is 2*CLK_DIV clk cycles, duty 50%.
- Capture: adc_input is registered on the clk edge where adc_clk goes 0→1, once per adc_clk period.
- The captured sample belongs to the current channel index. The index then advances (CH_COUNT-1 wraps to 0), and adc_sel takes the new index on that same edge.

Conversion and averaging:
- Conversion: if twos_comp=1, sample MSB is inverted and the value is treated as signed; otherwise it is unsigned.
- Per-channel accumulators are ADC_W+MAX_AVG_LOG2 bits wide and sign-/zero-extended.
- avg_log2 is clamped to MAX_AVG_LOG2. It is latched only at the start of each window; changes mid-window take effect at the next window.
- Window end: after 2^avg_log2 complete frames, each result = accumulator >> avg_log2. The shift is arithmetic when twos_comp=1 (floor rounding), then extended to OUT_W. Accumulators are cleared for the next window with no lost samples.
- Latency: the final capture of a window is the capture edge. The result register loads at edge+1. The FIFO write occurs at edge+2, and tvalid_m is high from the following cycle when the FIFO was empty.

Enable:
- enable=0 holds the divider, forces adc_clk=0 and channel index=0, and discards accumulators and partial window.
- The FIFO continues to drain while enable=0.
- enable 0→1 starts a fresh window at channel 0.

FIFO and output handshake:
- FIFO is first-word-fall-through. tvalid_m = FIFO not empty.
- A transfer occurs when tvalid_m & tready_m; tdata_m is held stable while tvalid_m & !tready_m.
- Push while full and no pop in the same cycle: frame is dropped and overflow is set.
- Push while full with a pop in the same cycle: push is accepted and fifo_level stays at FIFO_DEPTH.
- overflow_clr clears overflow; if a set and a clear happen in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_level updates the cycle after a push or pop.

Reset mid-operation:
- Everything returns to reset values immediately and asynchronously.
- Frames held in the FIFO are lost.

Test Plan:
1. CLK_DIV=2, CH_COUNT=2, enable=1 → adc_clk period 4 clk, adc_sel toggles every 4 clk, one frame every 8 clk with avg_log2=0.
2. twos_comp=1, avg_log2=0, ch0=10'h3FF, ch1=10'h000 → tdata_m=32'hFE00_01FF. With twos_comp=0 and the same inputs → 32'h0000_03FF.
3. twos_comp=0, avg_log2=2, ch0 sequence 100,101,102,103 → ch0 field = 0x0065. One frame per 32 clk. First frame appears 2 cycles after the 8th capture.
4. tready_m=0, FIFO_DEPTH=8 → fifo_level reaches 8; the 9th frame is dropped and overflow=1. Then tready_m=1 → 8 frames drain in order on 8 consecutive cycles, and overflow stays 1 until overflow_clr.
5. Same cycle: full FIFO, push, and tready_m=1 → no drop, overflow stays 0, fifo_level stays 8.
6. enable deasserted mid-window, then reasserted → partial window discarded, adc_clk=0 while disabled, first capture after re-enable is channel 0. reset_n pulsed mid-window → all outputs 0 asynchronously.
